// File: rtl/matmul_mem_master.sv
// Matrix-memory initiator: reads A rows and B columns, computes the 4x4 int8
// product one element at a time, and writes each 32-bit result to the C region.

module matmul_lane_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = a * b;
endmodule

module matmul_mem_master #(
  parameter int              ADDR_W = 10,
  parameter int              DATA_W = 32,
  parameter logic [ADDR_W-1:0] A_BASE = 10'h000,
  parameter logic [ADDR_W-1:0] B_BASE = 10'h100,
  parameter logic [ADDR_W-1:0] C_BASE = 10'h200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              read_en_A,
  output logic [ADDR_W-1:0] addr_A,
  input  logic [DATA_W-1:0] data_in_A,
  output logic              read_en_B,
  output logic [ADDR_W-1:0] addr_B,
  input  logic [DATA_W-1:0] data_in_B,
  output logic              write_en_C,
  output logic [ADDR_W-1:0] addr_C,
  output logic [DATA_W-1:0] data_out_C
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int SUM_W     = 16 + $clog2(NUM_LANES);

  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, FIN} state_t;

  state_t                         state, state_nxt;
  logic [1:0]                     i, j;
  logic [SUM_W-1:0]               sum, dot;
  logic [NUM_LANES-1:0][7:0]      a_lane, b_lane;
  logic [NUM_LANES-1:0][15:0]     prod;

  assign a_lane = data_in_A[8*NUM_LANES-1:0];
  assign b_lane = data_in_B[8*NUM_LANES-1:0];

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      matmul_lane_mul u_mul (.a(a_lane[l]), .b(b_lane[l]), .p(prod[l]));
    end
  endgenerate

  always_comb begin
    dot = '0;
    for (int n = 0; n < NUM_LANES; n++) dot = dot + SUM_W'(prod[n]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // {i,j} behaves as one 4-bit row-major element counter that wraps after (3,3).
  always_ff @(posedge clk) begin
    if (rst) begin
      i   <= '0;
      j   <= '0;
      sum <= '0;
    end else begin
      case (state)
        IDLE:    if (start) {i, j} <= '0;
        CALC:    sum <= dot;
        WRITE:   {i, j} <= {i, j} + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = CALC;
      CALC:    state_nxt = WRITE;
      WRITE:   state_nxt = ({i, j} == 4'hF) ? FIN : READ;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    read_en_A  = 1'b0;
    addr_A     = '0;
    read_en_B  = 1'b0;
    addr_B     = '0;
    write_en_C = 1'b0;
    addr_C     = '0;
    data_out_C = '0;
    case (state)
      READ: begin
        busy      = 1'b1;
        read_en_A = 1'b1;
        addr_A    = A_BASE + ADDR_W'(i);
        read_en_B = 1'b1;
        addr_B    = B_BASE + ADDR_W'(j);
      end
      CALC: busy = 1'b1;
      WRITE: begin
        busy       = 1'b1;
        write_en_C = 1'b1;
        addr_C     = C_BASE + ADDR_W'({i, j});
        data_out_C = DATA_W'(sum);
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_matmul_mem_master.sv
// Directed bench: memory model on all three ports, cycle-exact strobe checks
// against hand-derived timing, and result checks against closed-form products.

module tb_matmul_mem_master;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        busy, done;
  logic        read_en_A, read_en_B, write_en_C;
  logic [9:0]  addr_A, addr_B, addr_C;
  logic [31:0] data_in_A = '0, data_in_B = '0, data_out_C;

  logic [31:0] memA [4];
  logic [31:0] memB [4];
  logic [31:0] memC [16];
  logic [31:0] exp_c [16];
  logic        clr = 1'b0;
  int          nwr, ndone, nbusy;
  int          n_assert = 0, n_fail = 0;

  matmul_mem_master dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .read_en_A(read_en_A), .addr_A(addr_A), .data_in_A(data_in_A),
    .read_en_B(read_en_B), .addr_B(addr_B), .data_in_B(data_in_B),
    .write_en_C(write_en_C), .addr_C(addr_C), .data_out_C(data_out_C)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory; read data is junk unless a read was issued.
  always @(posedge clk) begin
    data_in_A <= read_en_A ? memA[addr_A[1:0]] : 32'hA5A5_A5A5;
    data_in_B <= read_en_B ? memB[addr_B[1:0]] : 32'h5A5A_5A5A;
    if (clr) begin
      for (int k = 0; k < 16; k++) memC[k] <= '0;
      nwr   <= 0;
      ndone <= 0;
      nbusy <= 0;
    end else begin
      if (write_en_C) begin
        memC[addr_C[3:0]] <= data_out_C;
        nwr <= nwr + 1;
      end
      if (done) ndone <= ndone + 1;
      if (busy) nbusy <= nbusy + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_c();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    ck({tag, " busy"},  32'(busy), 0);
    ck({tag, " done"},  32'(done), 0);
    ck({tag, " rd_a"},  32'(read_en_A), 0);
    ck({tag, " rd_b"},  32'(read_en_B), 0);
    ck({tag, " wr_c"},  32'(write_en_C), 0);
    ck({tag, " addr_a"}, 32'(addr_A), 0);
    ck({tag, " addr_b"}, 32'(addr_B), 0);
    ck({tag, " addr_c"}, 32'(addr_C), 0);
    ck({tag, " data_c"}, data_out_C, 0);
  endtask

  // Cycle c counts from the first READ; checks cycles 0..last, ticking after each.
  task automatic run_check(input bit pulse, input bit repulse, input bit chain, input int last);
    bit rd, wr;
    int k;
    if (pulse) begin
      start = 1'b1;
      tick();
    end
    for (int c = 0; c <= last; c++) begin
      start = 1'b0;
      k  = c / 3;
      rd = (c < 48) && (c % 3 == 0);
      wr = (c < 48) && (c % 3 == 2);
      ck($sformatf("c%0d rd_a", c), 32'(read_en_A), 32'(rd));
      ck($sformatf("c%0d rd_b", c), 32'(read_en_B), 32'(rd));
      ck($sformatf("c%0d addr_a", c), 32'(addr_A), rd ? 32'(k / 4) : 32'd0);
      ck($sformatf("c%0d addr_b", c), 32'(addr_B), rd ? 32'h100 + 32'(k % 4) : 32'd0);
      ck($sformatf("c%0d wr_c", c), 32'(write_en_C), 32'(wr));
      ck($sformatf("c%0d addr_c", c), 32'(addr_C), wr ? 32'h200 + 32'(k) : 32'd0);
      if (wr) ck($sformatf("c%0d data_c", c), data_out_C, exp_c[k]);
      ck($sformatf("c%0d busy", c), 32'(busy), 32'(c < 48));
      ck($sformatf("c%0d done", c), 32'(done), 32'(c == 48));
      if (repulse && (c == 5 || c == 48)) start = 1'b1;
      if (chain && c == 49) start = 1'b1;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic load_default();
    int a, b;
    for (int r = 0; r < 4; r++) begin
      memA[r] = {8'(4*r+4), 8'(4*r+3), 8'(4*r+2), 8'(4*r+1)};
      memB[r] = {8'(4*r+4), 8'(4*r+3), 8'(4*r+2), 8'(4*r+1)};
    end
    // sum_{n=0..3} (a+n)(b+n) = 4ab + 6(a+b) + 14
    for (int ii = 0; ii < 4; ii++)
      for (int jj = 0; jj < 4; jj++) begin
        a = 4*ii + 1;
        b = 4*jj + 1;
        exp_c[4*ii+jj] = 32'(4*a*b + 6*(a+b) + 14);
      end
  endtask

  task automatic chk_mem(input string tag);
    for (int k = 0; k < 16; k++) ck($sformatf("%s C[%0d]", tag, k), memC[k], exp_c[k]);
  endtask

  initial begin
    // Reset dominates a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    chk_idle("reset");
    rst   = 1'b0;
    start = 1'b0;
    clear_c();
    chk_idle("idle");

    // Default image: full timing and result check.
    load_default();
    run_check(1'b1, 1'b0, 1'b0, 51);
    ck("run1 writes", 32'(nwr), 16);
    ck("run1 dones", 32'(ndone), 1);
    ck("run1 busy cycles", 32'(nbusy), 48);
    ck("run1 C00", memC[0], 30);
    ck("run1 C03", memC[3], 150);
    ck("run1 C33", memC[15], 846);
    chk_mem("run1");

    // Saturating operands.
    for (int r = 0; r < 4; r++) begin
      memA[r] = 32'hFFFF_FFFF;
      memB[r] = 32'hFFFF_FFFF;
    end
    for (int k = 0; k < 16; k++) exp_c[k] = 32'h0003_F804;
    clear_c();
    run_check(1'b1, 1'b0, 1'b0, 51);
    ck("sat writes", 32'(nwr), 16);
    chk_mem("sat");

    // start re-pulsed while busy and in DONE is ignored.
    load_default();
    clear_c();
    run_check(1'b1, 1'b1, 1'b0, 51);
    ck("repulse writes", 32'(nwr), 16);
    ck("repulse dones", 32'(ndone), 1);
    chk_mem("repulse");

    // Reset in the WRITE cycle of element 6.
    clear_c();
    run_check(1'b1, 1'b0, 1'b0, 19);
    ck("c20 wr_c", 32'(write_en_C), 1);
    ck("c20 addr_c", 32'(addr_C), 32'h206);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("post-rst c21");
    for (int c = 22; c < 26; c++) begin
      tick();
      chk_idle($sformatf("post-rst c%0d", c));
    end
    ck("rst writes", 32'(nwr), 7);
    ck("rst dones", 32'(ndone), 0);
    ck("rst C[6]", memC[6], exp_c[6]);
    ck("rst C[7]", memC[7], 0);

    // Fresh run after the aborted one.
    clear_c();
    run_check(1'b1, 1'b0, 1'b0, 51);
    ck("fresh writes", 32'(nwr), 16);
    ck("fresh dones", 32'(ndone), 1);
    chk_mem("fresh");

    // Back-to-back: start in the IDLE cycle right after DONE.
    clear_c();
    run_check(1'b1, 1'b0, 1'b1, 49);
    run_check(1'b0, 1'b0, 1'b0, 51);
    ck("b2b writes", 32'(nwr), 32);
    ck("b2b dones", 32'(ndone), 2);
    ck("b2b busy cycles", 32'(nbusy), 96);
    chk_mem("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
